// File: rtl/result_mem_writer.sv
// Drains dot-product results from the result FIFO into consecutive mem3 words.
// Tracks the write pointer, a saturating result count and a sticky wrap flag.
module result_mem_writer #(
   parameter int DATA_WIDTH   = 32,
   parameter int RESULT_WIDTH = 16,
   parameter int ADDR_WIDTH   = 5,
   parameter int MEM_SIZE     = 32,
   parameter int START_ADDR   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    clear,
   input  logic                    fifo_empty,
   input  logic [RESULT_WIDTH-1:0] fifo_dout,
   output logic                    fifo_rd_en,
   output logic                    mem_write_en,
   output logic [ADDR_WIDTH-1:0]   mem_write_address,
   output logic [DATA_WIDTH-1:0]   mem_data_in,
   output logic [15:0]             result_count,
   output logic                    wrapped,
   output logic                    busy
);

   // state   | meaning
   // IDLE    | waiting for start with a non-empty FIFO
   // CAPTURE | popped result arrives on fifo_dout this cycle
   // WRITE   | captured result presented to mem3
   typedef enum logic [1:0] {IDLE, CAPTURE, WRITE} state_t;

   localparam logic [ADDR_WIDTH-1:0] START_PTR = ADDR_WIDTH'(START_ADDR);
   localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(MEM_SIZE - 1);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
   logic [15:0]             count_q, count_d;
   logic                    wrapped_q, wrapped_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= START_PTR;
         count_q   <= '0;
         wrapped_q <= 1'b0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         count_q   <= count_d;
         wrapped_q <= wrapped_d;
         data_q    <= data_d;
      end
   end

   always_comb begin
      // rst gates the pop so a held reset never drains the FIFO
      fifo_rd_en = ((state_q == IDLE) || (state_q == WRITE)) && start &&
                   !fifo_empty && !clear && !rst;
      state_d   = state_q;
      ptr_d     = ptr_q;
      count_d   = count_q;
      wrapped_d = wrapped_q;
      data_d    = data_q;

      case (state_q)
         IDLE: begin
            if (fifo_rd_en) state_d = CAPTURE;
         end
         CAPTURE: begin
            data_d  = DATA_WIDTH'(fifo_dout);
            state_d = WRITE;
         end
         WRITE: begin
            if (ptr_q == LAST_PTR) begin
               ptr_d     = '0;
               wrapped_d = 1'b1;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
            state_d = fifo_rd_en ? CAPTURE : IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A clear in WRITE still lets this cycle's strobe reach mem3
      if (clear) begin
         state_d   = IDLE;
         ptr_d     = START_PTR;
         count_d   = '0;
         wrapped_d = 1'b0;
         data_d    = data_q;
      end
   end

   assign mem_write_en      = (state_q == WRITE);
   assign mem_write_address = ptr_q;
   assign mem_data_in       = data_q;
   assign result_count      = count_q;
   assign wrapped           = wrapped_q;
   assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_result_mem_writer.sv
// Self-checking bench for result_mem_writer: FIFO model, write/pop logs,
// a table of single-result vectors and hand-written multi-cycle sequences.
module tb_result_mem_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        clear = 1'b0;
   logic        fifo_empty;
   logic [15:0] fifo_dout = '0;
   logic        fifo_rd_en;
   logic        mem_write_en;
   logic [4:0]  mem_write_address;
   logic [31:0] mem_data_in;
   logic [15:0] result_count;
   logic        wrapped;
   logic        busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [15:0] fdata [1024];
   int n_push = 0;
   int n_pop = 0;

   int          rd_log [$];
   int          wr_cyc [$];
   logic [4:0]  wr_addr [$];
   logic [31:0] wr_data [$];
   logic        wr_wrap [$];

   typedef struct {
      logic [15:0] val;
      logic [31:0] exp_data;
      logic [4:0]  exp_addr;
      logic [15:0] exp_count;
   } vec_t;
   vec_t vecs [5];

   result_mem_writer dut (
      .clk(clk), .rst(rst), .start(start), .clear(clear),
      .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
      .fifo_rd_en(fifo_rd_en), .mem_write_en(mem_write_en),
      .mem_write_address(mem_write_address), .mem_data_in(mem_data_in),
      .result_count(result_count), .wrapped(wrapped), .busy(busy)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (n_push == n_pop);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rd_en && (n_push != n_pop)) begin
         fifo_dout <= fdata[n_pop % 1024];
         n_pop     <= n_pop + 1;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (fifo_rd_en) rd_log.push_back(cyc);
         if (mem_write_en) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(mem_write_address);
            wr_data.push_back(mem_data_in);
            wr_wrap.push_back(wrapped);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] v);
      fdata[n_push % 1024] = v;
      n_push++;
   endtask

   task automatic run_until_done(input int max);
      int n = 0;
      tick();
      while ((busy || !fifo_empty) && n < max) begin
         tick();
         n++;
      end
      if (n >= max) chk("timeout_done", 32'(n), 32'(max - 1));
   endtask

   initial begin
      int n0, rb, wb;

      vecs[0] = '{16'h0000, 32'h0000_0000, 5'd4, 16'd4};
      vecs[1] = '{16'hFFFF, 32'h0000_FFFF, 5'd5, 16'd5};
      vecs[2] = '{16'h8000, 32'h0000_8000, 5'd6, 16'd6};
      vecs[3] = '{16'h1234, 32'h0000_1234, 5'd7, 16'd7};
      vecs[4] = '{16'h00C3, 32'h0000_00C3, 5'd8, 16'd8};

      // reset held with start=1 and a non-empty FIFO
      start = 1'b1;
      push(16'd30);
      repeat (3) tick();
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("rst_wr_en", 32'(mem_write_en), 32'd0);
      chk("rst_addr", 32'(mem_write_address), 32'd1);
      chk("rst_data", mem_data_in, 32'd0);
      chk("rst_count", 32'(result_count), 32'd0);
      chk("rst_wrapped", 32'(wrapped), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      // single result
      rb = rd_log.size(); wb = wr_cyc.size();
      rst = 1'b0;
      #1;
      n0 = cyc;
      chk("single_rd_en_now", 32'(fifo_rd_en), 32'd1);
      run_until_done(20);
      chk("single_rd_cnt", 32'(rd_log.size() - rb), 32'd1);
      chk("single_wr_cnt", 32'(wr_cyc.size() - wb), 32'd1);
      if (rd_log.size() > rb) chk("single_rd_cyc", 32'(rd_log[rb]), 32'(n0));
      if (wr_cyc.size() > wb) begin
         chk("single_wr_cyc", 32'(wr_cyc[wb]), 32'(n0 + 2));
         chk("single_wr_addr", 32'(wr_addr[wb]), 32'd1);
         chk("single_wr_data", wr_data[wb], 32'd30);
      end
      chk("single_count", 32'(result_count), 32'd1);
      chk("single_addr_after", 32'(mem_write_address), 32'd2);
      chk("single_busy", 32'(busy), 32'd0);

      // back-to-back after an idle clear
      start = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_idle_count", 32'(result_count), 32'd0);
      chk("clr_idle_addr", 32'(mem_write_address), 32'd1);
      push(16'd30); push(16'd54); push(16'd86);
      rb = rd_log.size(); wb = wr_cyc.size();
      start = 1'b1;
      #1;
      n0 = cyc;
      run_until_done(30);
      chk("b2b_wr_cnt", 32'(wr_cyc.size() - wb), 32'd3);
      chk("b2b_rd_cnt", 32'(rd_log.size() - rb), 32'd3);
      for (int i = 0; i < 3; i++) begin
         if (wr_cyc.size() > wb + i) begin
            chk($sformatf("b2b_wr_cyc%0d", i), 32'(wr_cyc[wb + i]), 32'(n0 + 2 + 2 * i));
            chk($sformatf("b2b_wr_addr%0d", i), 32'(wr_addr[wb + i]), 32'(i + 1));
         end
         if (rd_log.size() > rb + i)
            chk($sformatf("b2b_rd_cyc%0d", i), 32'(rd_log[rb + i]), 32'(n0 + 2 * i));
      end
      if (wr_data.size() > wb + 2) begin
         chk("b2b_data0", wr_data[wb], 32'd30);
         chk("b2b_data1", wr_data[wb + 1], 32'd54);
         chk("b2b_data2", wr_data[wb + 2], 32'd86);
      end
      chk("b2b_count", 32'(result_count), 32'd3);

      // table of single results continuing from pointer 4
      foreach (vecs[k]) begin
         wb = wr_cyc.size();
         push(vecs[k].val);
         #1;
         run_until_done(20);
         chk($sformatf("vec%0d_wr_cnt", k), 32'(wr_cyc.size() - wb), 32'd1);
         if (wr_cyc.size() > wb) begin
            chk($sformatf("vec%0d_addr", k), 32'(wr_addr[wb]), 32'(vecs[k].exp_addr));
            chk($sformatf("vec%0d_data", k), wr_data[wb], vecs[k].exp_data);
         end
         chk($sformatf("vec%0d_count", k), 32'(result_count), 32'(vecs[k].exp_count));
      end

      // wrap: 32 results streamed from reset
      start = 1'b0;
      rst = 1'b1;
      #1;
      chk("async_rst_addr", 32'(mem_write_address), 32'd1);
      chk("async_rst_count", 32'(result_count), 32'd0);
      tick();
      for (int i = 0; i < 32; i++) push(16'(100 + i));
      wb = wr_cyc.size();
      rst = 1'b0;
      start = 1'b1;
      #1;
      run_until_done(200);
      chk("wrap_wr_cnt", 32'(wr_cyc.size() - wb), 32'd32);
      if (wr_cyc.size() >= wb + 32) begin
         for (int i = 0; i < 32; i++) begin
            chk($sformatf("wrap_addr%0d", i), 32'(wr_addr[wb + i]), 32'((i + 1) % 32));
            chk($sformatf("wrap_data%0d", i), wr_data[wb + i], 32'(100 + i));
         end
         chk("wrap_flag_at31", 32'(wr_wrap[wb + 30]), 32'd0);
         chk("wrap_flag_at0", 32'(wr_wrap[wb + 31]), 32'd1);
      end
      chk("wrap_count", 32'(result_count), 32'd32);
      chk("wrap_addr_end", 32'(mem_write_address), 32'd1);
      chk("wrap_flag_end", 32'(wrapped), 32'd1);

      // clear in CAPTURE discards the popped result
      wb = wr_cyc.size();
      push(16'h0055);
      #1;
      tick();
      chk("clrcap_busy_before", 32'(busy), 32'd1);
      clear = 1'b1;
      start = 1'b0;
      tick();
      clear = 1'b0;
      chk("clrcap_busy", 32'(busy), 32'd0);
      chk("clrcap_addr", 32'(mem_write_address), 32'd1);
      chk("clrcap_count", 32'(result_count), 32'd0);
      chk("clrcap_wrapped", 32'(wrapped), 32'd0);
      repeat (4) tick();
      chk("clrcap_no_write", 32'(wr_cyc.size() - wb), 32'd0);

      // start dropped in CAPTURE with two results queued
      push(16'd7); push(16'd9);
      rb = rd_log.size(); wb = wr_cyc.size();
      start = 1'b1;
      #1;
      tick();
      start = 1'b0;
      tick();
      chk("drop_wr_en", 32'(mem_write_en), 32'd1);
      chk("drop_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("drop_addr", 32'(mem_write_address), 32'd1);
      repeat (5) tick();
      chk("drop_rd_cnt", 32'(rd_log.size() - rb), 32'd1);
      chk("drop_wr_cnt", 32'(wr_cyc.size() - wb), 32'd1);
      chk("drop_busy", 32'(busy), 32'd0);
      start = 1'b1;
      #1;
      chk("drop_resume_rd_en", 32'(fifo_rd_en), 32'd1);
      run_until_done(20);
      chk("drop_count", 32'(result_count), 32'd2);
      if (wr_data.size() > wb + 1) chk("drop_data2", wr_data[wb + 1], 32'd9);

      // rst pulsed during WRITE
      push(16'h00AB);
      #1;
      tick();
      tick();
      chk("rstwr_wr_en", 32'(mem_write_en), 32'd1);
      chk("rstwr_data", mem_data_in, 32'h0000_00AB);
      chk("rstwr_addr", 32'(mem_write_address), 32'd3);
      rst = 1'b1;
      #1;
      chk("rstwr_wr_en_rst", 32'(mem_write_en), 32'd0);
      chk("rstwr_addr_rst", 32'(mem_write_address), 32'd1);
      chk("rstwr_data_rst", mem_data_in, 32'd0);
      chk("rstwr_count_rst", 32'(result_count), 32'd0);
      chk("rstwr_busy_rst", 32'(busy), 32'd0);
      chk("rstwr_rd_en_rst", 32'(fifo_rd_en), 32'd0);
      start = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/result_mem_writer.md
# result_mem_writer

Drain stage between the dot-product result FIFO and the result memory (mem3). While enabled, it pops each dot-product result from the FIFO, zero-extends it to memory word width, and writes it to consecutive mem3 addresses starting at START_ADDR (1). It tracks the write pointer, a saturating result count and a sticky wrap flag, so the controlling FSM and the host know how many results landed and where.

## Interface
- DATA_WIDTH, 32, mem3 word width; must be ≥ RESULT_WIDTH
- RESULT_WIDTH, 16, dot-product result width from the FIFO
- ADDR_WIDTH, 5, mem3 address width
- MEM_SIZE, 32, mem3 depth in words; address range is 0..MEM_SIZE-1
- START_ADDR, 1, first address written after reset or clear
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  level enable; new FIFO pops are issued only while high
- clear  in  1  synchronous restart of pointer, count and flag
- fifo_empty  in  1  result FIFO empty flag
- fifo_dout  in  RESULT_WIDTH  FIFO read data, valid the cycle after fifo_rd_en
- fifo_rd_en  out  1  FIFO pop strobe, one cycle per result
- mem_write_en  out  1  mem3 write strobe
- mem_write_address  out  ADDR_WIDTH  mem3 write address (current pointer)
- mem_data_in  out  DATA_WIDTH  mem3 write data, zero-extended result
- result_count  out  16  number of completed writes, saturating
- wrapped  out  1  sticky; set when the pointer wraps from MEM_SIZE-1 to 0
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, CAPTURE, WRITE.
- fifo_rd_en is a combinational decode: (state==IDLE or state==WRITE) && start && !fifo_empty && !clear.
- IDLE: if fifo_rd_en then → CAPTURE, else stay in IDLE.
- CAPTURE: register fifo_dout into mem_data_in (upper DATA_WIDTH-RESULT_WIDTH bits 0), then → WRITE unconditionally.
- WRITE: mem_write_en=1 with mem_write_address=pointer. At the clock edge:
  - pointer <= pointer+1; after MEM_SIZE-1 it wraps to 0 and sets wrapped.
  - result_count increments, holding at 16'hFFFF once reached.
  - If fifo_rd_en then → CAPTURE (back-to-back), else → IDLE.
- Dropping start never aborts an in-flight result. A pop already issued always completes its write; only new pops are blocked.
- clear has priority over everything except rst. At the edge it sets:
  - state <= IDLE, pointer <= START_ADDR, result_count <= 0, wrapped <= 0.
  - If clear arrives in CAPTURE, the popped result is discarded and not written.
  - If clear arrives in WRITE, the write strobe in that cycle still reaches mem3, but the pointer and count take their clear values.
- Reset values (asynchronous, immediate):
  - state=IDLE, mem_write_en=0, mem_write_address=START_ADDR, mem_data_in=0.
  - result_count=0, wrapped=0, busy=0.
  - fifo_rd_en=0, because state is IDLE and start is ignored while rst is high.

## Timing
- Latency: fifo_rd_en high in cycle N → data captured at end of N+1 → mem_write_en high for exactly cycle N+2. The pointer and count update at the end of N+2.
- Throughput: one result per 2 cycles when start=1 and the FIFO stays non-empty. fifo_rd_en is asserted in each WRITE cycle.
- mem_write_en, mem_write_address and mem_data_in are register/state-decoded, so they are glitch-free and stable for the whole WRITE cycle.
- FIFO becomes empty during WRITE: that write completes and the block returns to IDLE.
- start and fifo_empty are sampled combinationally only in IDLE/WRITE. In CAPTURE they have no effect.
- rst asserted mid-transaction: outputs take reset values immediately, and any captured data is lost.

## Test plan
- Reset: hold rst=1 with start=1 and FIFO non-empty → fifo_rd_en=0, mem_write_en=0, mem_write_address=1, result_count=0, wrapped=0, busy=0.
- Single result: FIFO holds 16'd30, start=1 → fifo_rd_en high in cycle N only. mem_write_en high in N+2 with address 1 and data 32'd30. Afterwards result_count=1, mem_write_address=2, busy=0.
- Back-to-back: FIFO holds 30, 54, 86 → writes in cycles N+2, N+4, N+6 to addresses 1, 2, 3 with data 30, 54, 86. result_count=3 at the end.
- Wrap: 32 results streamed from reset → addresses 1..31, then 0. wrapped rises at the end of the write to address 31. result_count=32 and mem_write_address=1 at the end.
- start dropped in CAPTURE with 2 results queued → the pending write completes; no further fifo_rd_en until start returns to 1.
- clear in CAPTURE → no write occurs; pointer=1, count=0, wrapped=0, state=IDLE. Separately, rst pulsed during WRITE → all outputs return to reset values within the same cycle.
